// File: rtl/v_red_pkg.sv
// Shared types for the vector reduce/accumulate block: op codes, FSM states, chunking constants.
// Optional feature macro: V_RED_SAT_EN (saturating SUM, see v_red_chunk / v_reduce_acc).
package v_red_pkg;

  typedef enum logic [1:0] {
    RED_SUM16 = 2'd0,
    RED_SUM32 = 2'd1,
    RED_MAX16 = 2'd2,
    RED_MAX32 = 2'd3
  } red_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RED  = 2'd1,
    OUT  = 2'd2
  } red_st_e;

  localparam int VREG_DW_DEF = 512;
  localparam int CHUNK_W_DEF = 128;
  localparam int NCHUNK      = VREG_DW_DEF / CHUNK_W_DEF;

  localparam logic [31:0] MAX_INIT = 32'h8000_0000;

endpackage

// File: rtl/v_reduce_acc_if.sv
// Input vector stream + output scalar stream of v_reduce_acc; slave = the reducer, master = its environment.
// sat_o exists only when V_RED_SAT_EN is defined.
interface v_reduce_acc_if #(
  parameter int VREG_DW = 512,
  parameter int CNT_W   = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [VREG_DW-1:0] in_vec;
  logic [1:0]         in_op;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        result_o;
  logic [CNT_W-1:0]   grp_len_o;
`ifdef V_RED_SAT_EN
  logic               sat_o;
`endif

  modport slave (
    input  in_valid, in_vec, in_op, in_last, out_ready,
    output in_ready, out_valid, result_o, grp_len_o
`ifdef V_RED_SAT_EN
    , output sat_o
`endif
  );

  modport master (
    output in_valid, in_vec, in_op, in_last, out_ready,
    input  in_ready, out_valid, result_o, grp_len_o
`ifdef V_RED_SAT_EN
    , input sat_o
`endif
  );
endinterface

// File: rtl/v_red_chunk.sv
// Combinational reduction of one CHUNK_W slice into the running accumulator (SUM or MAX, 16b/32b lanes).
// V_RED_SAT_EN: SUM clamps to the int32 range and raises sat.
module v_red_chunk import v_red_pkg::*; #(
  parameter int CHUNK_W = 128
) (
  input  logic [CHUNK_W-1:0] chunk,
  input  red_op_e            op,
  input  logic [31:0]        acc,
  output logic [31:0]        acc_nxt
`ifdef V_RED_SAT_EN
  , output logic             sat
`endif
);
  localparam int L16 = CHUNK_W / 16;
  localparam int L32 = CHUNK_W / 32;
  // Wrapping needs only the low 32 bits of the sum; clamping needs headroom to see the overflow.
`ifdef V_RED_SAT_EN
  localparam int SUM_W = 36;
  localparam logic signed [SUM_W-1:0] S_MAX = 36'sh0_7FFF_FFFF;
  localparam logic signed [SUM_W-1:0] S_MIN = 36'shF_8000_0000;
`else
  localparam int SUM_W = 32;
`endif

  logic signed [31:0] l16 [L16];
  logic signed [31:0] l32 [L32];

  for (genvar g = 0; g < L16; g++) begin : g_l16
    assign l16[g] = 32'(signed'(chunk[g*16 +: 16]));
  end
  for (genvar g = 0; g < L32; g++) begin : g_l32
    assign l32[g] = signed'(chunk[g*32 +: 32]);
  end

  logic signed [SUM_W-1:0] sum;
  logic signed [31:0]      mx;

  always_comb begin
    sum = SUM_W'(signed'(acc));
    mx  = signed'(acc);
    if (op[0]) begin
      for (int i = 0; i < L32; i++) begin
        sum = sum + SUM_W'(l32[i]);
        if (l32[i] > mx) mx = l32[i];
      end
    end else begin
      for (int i = 0; i < L16; i++) begin
        sum = sum + SUM_W'(l16[i]);
        if (l16[i] > mx) mx = l16[i];
      end
    end
  end

  always_comb begin
    acc_nxt = op[1] ? mx : sum[31:0];
`ifdef V_RED_SAT_EN
    sat = 1'b0;
    if (!op[1]) begin
      if (sum > S_MAX) begin
        acc_nxt = 32'h7FFF_FFFF;
        sat     = 1'b1;
      end else if (sum < S_MIN) begin
        acc_nxt = 32'h8000_0000;
        sat     = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/v_reduce_acc.sv
// Iterative horizontal reducer: one VALU vector per NCH cycles, accumulated across a group to a 32b scalar.
// V_RED_SAT_EN: saturating SUM with sticky per-group sat_o.
module v_reduce_acc import v_red_pkg::*; #(
  parameter int VREG_DW = 512,
  parameter int CHUNK_W = 128,
  parameter int CNT_W   = 8
) (
  input logic           clk,
  input logic           rst,
  v_reduce_acc_if.slave bus
);
  localparam int NCH   = VREG_DW / CHUNK_W;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  red_st_e                     st, st_nxt;
  logic [NCH-1:0][CHUNK_W-1:0] vec_q;
  logic                        last_q, grp_open;
  red_op_e                     op_q;
  logic [IDX_W-1:0]            idx;
  logic [31:0]                 acc, acc_nxt, res_q;
  logic [CNT_W-1:0]            cnt, cnt_inc, len_q;
  logic                        accept, last_chunk;
`ifdef V_RED_SAT_EN
  logic                        sat_c, sat_q;
`endif

  assign accept     = bus.in_valid && (st == IDLE);
  assign last_chunk = (st == RED) && (idx == IDX_W'(NCH - 1));
  assign cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  v_red_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
    .chunk   (vec_q[idx]),
    .op      (op_q),
    .acc     (acc),
    .acc_nxt (acc_nxt)
`ifdef V_RED_SAT_EN
    , .sat   (sat_c)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:    if (bus.in_valid) st_nxt = RED;
      RED:     if (last_chunk)   st_nxt = last_q ? OUT : IDLE;
      OUT:     if (bus.out_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (st == IDLE);
    bus.out_valid = (st == OUT);
    bus.result_o  = res_q;
    bus.grp_len_o = len_q;
`ifdef V_RED_SAT_EN
    bus.sat_o     = sat_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q    <= '0;
      last_q   <= 1'b0;
      grp_open <= 1'b0;
      op_q     <= RED_SUM16;
      idx      <= '0;
      acc      <= '0;
      cnt      <= '0;
      res_q    <= '0;
      len_q    <= '0;
`ifdef V_RED_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        vec_q  <= bus.in_vec;
        last_q <= bus.in_last;
        idx    <= '0;
        // Op is fixed by the first vector of a group; later in_op values are ignored.
        if (!grp_open) begin
          op_q     <= red_op_e'(bus.in_op);
          acc      <= bus.in_op[1] ? MAX_INIT : 32'd0;
          cnt      <= '0;
          grp_open <= 1'b1;
`ifdef V_RED_SAT_EN
          sat_q    <= 1'b0;
`endif
        end
      end
      if (st == RED) begin
        acc <= acc_nxt;
        idx <= idx + 1'b1;
`ifdef V_RED_SAT_EN
        sat_q <= sat_q | sat_c;
`endif
        if (last_chunk) begin
          cnt <= cnt_inc;
          if (last_q) begin
            res_q <= acc_nxt;
            len_q <= cnt_inc;
          end
        end
      end
      if (st == OUT && bus.out_ready) grp_open <= 1'b0;
    end
  end

endmodule

// File: tb/tb_v_reduce_acc.sv
// Directed bench for v_reduce_acc: latency, SUM/MAX lanes, grouping, backpressure, reset, wrap/saturation.
// Expected values follow V_RED_SAT_EN when it is defined.
module tb_v_reduce_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  v_reduce_acc_if #(.VREG_DW(512), .CNT_W(8)) bus ();
  v_reduce_acc #(.VREG_DW(512), .CHUNK_W(128), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  logic [511:0] v;

  task automatic drive(input logic [511:0] vec, input logic [1:0] op, input logic last);
    int n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n_chk++;
    if (n >= 50) begin n_fail++; $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_vec = vec; bus.in_op = op; bus.in_last = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (bus.out_valid !== 1'b1 && lat < 50);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_vec = '0; bus.in_op = 2'd0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    n_chk++; if (bus.result_o !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h required 0", bus.result_o); end
    n_chk++; if (bus.grp_len_o !== 8'd0) begin n_fail++; $display("FAIL reset_grp_len: got %0d required 0", bus.grp_len_o); end
  endtask

  task automatic test_sum32();
    int lat;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(i + 1);
    drive(v, 2'd1, 1'b1);
    wait_out(lat);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL sum32_latency: got %0d required 5", lat); end
    n_chk++; if (bus.result_o !== 32'd136) begin n_fail++; $display("FAIL sum32_result: got %h required %h", bus.result_o, 32'd136); end
    n_chk++; if (bus.grp_len_o !== 8'd1) begin n_fail++; $display("FAIL sum32_grp_len: got %0d required 1", bus.grp_len_o); end
    take();
  endtask

  task automatic test_sum16_max16();
    int lat;
    v = '1;
    drive(v, 2'd0, 1'b1);
    wait_out(lat);
    n_chk++; if (bus.result_o !== 32'hFFFF_FFE0) begin n_fail++; $display("FAIL sum16_neg: got %h required ffffffe0", bus.result_o); end
    take();
    v[5*16 +: 16] = 16'h7FFF;
    drive(v, 2'd2, 1'b1);
    wait_out(lat);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL max16_latency: got %0d required 5", lat); end
    n_chk++; if (bus.result_o !== 32'h0000_7FFF) begin n_fail++; $display("FAIL max16_result: got %h required 00007fff", bus.result_o); end
    take();
  endtask

  task automatic test_max_group();
    int lat;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(i * 10 - 300);
    drive(v, 2'd3, 1'b0);
    repeat (8) @(negedge clk);
    n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin n_fail++; $display("FAIL group_mid_idle: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready); end
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = (i == 9) ? 32'd1000 : -32'sd7;
    drive(v, 2'd1, 1'b0);
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(i * 50);
    drive(v, 2'd1, 1'b1);
    wait_out(lat);
    n_chk++; if (bus.result_o !== 32'd1000) begin n_fail++; $display("FAIL group_max: got %0d required 1000", $signed(bus.result_o)); end
    n_chk++; if (bus.grp_len_o !== 8'd3) begin n_fail++; $display("FAIL group_len: got %0d required 3", bus.grp_len_o); end
    take();
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(i + 1);
    drive(v, 2'd1, 1'b1);
    wait_out(lat);
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'd2;
    bus.in_valid = 1'b1; bus.in_vec = v; bus.in_op = 2'd1; bus.in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++; if (bus.out_valid !== 1'b1 || bus.result_o !== 32'd136)
        begin n_fail++; $display("FAIL bp_hold[%0d]: out_valid=%b result=%0d required 1/136", c, bus.out_valid, bus.result_o); end
      n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b required 0", c, bus.in_ready); end
    end
    take();
    @(negedge clk);
    n_chk++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(lat);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL bp_latency: got %0d required 5", lat); end
    n_chk++; if (bus.result_o !== 32'd32 || bus.grp_len_o !== 8'd1)
      begin n_fail++; $display("FAIL bp_next: result=%0d len=%0d required 32/1", bus.result_o, bus.grp_len_o); end
    take();
  endtask

  task automatic test_rst_mid();
    int lat;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'd100;
    drive(v, 2'd1, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_hs: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid); end
    n_chk++; if (bus.result_o !== 32'd0 || bus.grp_len_o !== 8'd0)
      begin n_fail++; $display("FAIL rst_mid_regs: result=%h len=%0d required 0/0", bus.result_o, bus.grp_len_o); end
    repeat (8) @(negedge clk);
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_out: got %b required 0", bus.out_valid); end
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'd1;
    drive(v, 2'd1, 1'b1);
    wait_out(lat);
    n_chk++; if (bus.result_o !== 32'd16 || bus.grp_len_o !== 8'd1)
      begin n_fail++; $display("FAIL rst_fresh: result=%0d len=%0d required 16/1", bus.result_o, bus.grp_len_o); end
    take();
  endtask

  task automatic test_wrap_sat();
    int lat;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'h7FFF_FFFF;
    drive(v, 2'd1, 1'b1);
    wait_out(lat);
`ifdef V_RED_SAT_EN
    n_chk++; if (bus.result_o !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_result: got %h required 7fffffff", bus.result_o); end
    n_chk++; if (bus.sat_o !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b required 1", bus.sat_o); end
`else
    n_chk++; if (bus.result_o !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL wrap_result: got %h required fffffff0", bus.result_o); end
`endif
    take();
  endtask

  task automatic test_grp_len_sat();
    int lat;
    v = '0;
    for (int k = 0; k < 256; k++) drive(v, 2'd0, (k == 255) ? 1'b1 : 1'b0);
    wait_out(lat);
    n_chk++; if (bus.grp_len_o !== 8'd255 || bus.result_o !== 32'd0)
      begin n_fail++; $display("FAIL grp_len_sat: len=%0d result=%h required 255/0", bus.grp_len_o, bus.result_o); end
`ifdef V_RED_SAT_EN
    n_chk++; if (bus.sat_o !== 1'b0) begin n_fail++; $display("FAIL sat_cleared: got %b required 0", bus.sat_o); end
`endif
    take();
  endtask

  initial begin
    test_reset();
    test_sum32();
    test_sum16_max16();
    test_max_group();
    test_back_to_back();
    test_rst_mid();
    test_wrap_sat();
    test_grp_len_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
